// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler
//   Shares one small ALU (ADD/SUB/MUL/DIV) between two requesters. A
//   round-robin arbiter picks a requester while idle; ADD/SUB finish in one
//   cycle, MUL (shift-add) and DIV (restoring) iterate for WIDTH cycles. The
//   result is held on a valid/ready response port until the consumer takes it.
//
//   Optional feature macro: ALU_DIVZERO_EN
//     defined   : DIV by zero is caught at accept, returns result 0, rsp_err 1
//                 one cycle later without iterating.
//     undefined : DIV by zero iterates normally (all-ones quotient), rsp_err 0.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (0/1)
//   reqN_op                  00 ADD, 01 SUB, 10 MUL, 11 DIV
//   reqN_a, reqN_b           operands (WIDTH bits, unsigned)
//   rsp_valid/rsp_ready      response handshake
//   rsp_id                   requester that owns the response
//   rsp_result               WIDTH-bit result (mod 2^WIDTH)
//   rsp_err                  divide-by-zero flag
//   busy                     high whenever the scheduler is not idle
module alu_req_scheduler #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_err,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_err_q, rsp_err_d;

   // Iteration working registers. MUL: x = shifted multiplicand,
   // y = shifted multiplier, acc = partial product. DIV: x = dividend
   // shifting out / quotient shifting in, y = divisor, acc = remainder.
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] acc_q, acc_d;

   logic             any_valid;
   logic             grant;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_a, sel_b;

   logic [WIDTH-1:0] mul_acc_nxt;
   logic [WIDTH:0]   rem_sh;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_diff, rem_nxt, quo_nxt;

   // Arbitration: a lone requester always wins; on contention rr_ptr decides.
   always_comb begin
      any_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) grant = rr_ptr_q;
      else                          grant = ~req0_valid;
      sel_op = grant ? req1_op : req0_op;
      sel_a  = grant ? req1_a  : req0_a;
      sel_b  = grant ? req1_b  : req0_b;
   end

   assign req0_ready = (state_q == IDLE) & any_valid & ~grant;
   assign req1_ready = (state_q == IDLE) & any_valid &  grant;

   // One iteration of each multi-cycle algorithm.
   always_comb begin
      mul_acc_nxt = acc_q + (y_q[0] ? x_q : '0);
      // The remainder stays below the divisor, so after shifting in one
      // dividend bit it fits in WIDTH+1 bits and the difference in WIDTH.
      rem_sh      = {acc_q, x_q[WIDTH-1]};
      rem_ge      = (rem_sh >= {1'b0, y_q});
      rem_diff    = rem_sh[WIDTH-1:0] - y_q;
      rem_nxt     = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
      quo_nxt     = {x_q[WIDTH-2:0], rem_ge};
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      op_d         = op_q;
      x_d          = x_q;
      y_d          = y_q;
      acc_d        = acc_q;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               rr_ptr_d  = ~grant;
               rsp_id_d  = grant;
               rsp_err_d = 1'b0;
               op_d      = sel_op;
               x_d       = sel_a;
               y_d       = sel_b;
               acc_d     = '0;
               cnt_d     = '0;
               case (sel_op)
                  OP_ADD: begin
                     rsp_result_d = sel_a + sel_b;
                     rsp_valid_d  = 1'b1;
                     state_d      = DONE;
                  end
                  OP_SUB: begin
                     rsp_result_d = sel_a - sel_b;
                     rsp_valid_d  = 1'b1;
                     state_d      = DONE;
                  end
                  OP_MUL: begin
                     state_d = EXEC;
                  end
                  default: begin
`ifdef ALU_DIVZERO_EN
                     if (sel_b == '0) begin
                        rsp_result_d = '0;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = DONE;
                     end else begin
                        state_d = EXEC;
                     end
`else
                     state_d = EXEC;
`endif
                  end
               endcase
            end
         end
         EXEC: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (op_q == OP_DIV) begin
               acc_d = rem_nxt;
               x_d   = quo_nxt;
            end else begin
               acc_d = mul_acc_nxt;
               x_d   = {x_q[WIDTH-2:0], 1'b0};
               y_d   = y_q >> 1;
            end
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               rsp_result_d = (op_q == OP_DIV) ? quo_nxt : mul_acc_nxt;
               rsp_valid_d  = 1'b1;
               state_d      = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= 1'b0;
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   // Working registers are only meaningful after an accept, so no reset.
   always_ff @(posedge clk) begin
      op_q  <= op_d;
      x_q   <= x_d;
      y_q   <= y_d;
      acc_q <= acc_d;
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
`ifdef ALU_DIVZERO_EN
   assign rsp_err    = rsp_err_q;
`else
   assign rsp_err    = 1'b0;
`endif
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb_alu_req_scheduler
//   Self-checking bench for alu_req_scheduler (WIDTH=4). A transaction-level
//   reference model (phase + countdown + round-robin pointer, results from
//   plain arithmetic) predicts ready/valid/result every cycle. Directed
//   scenarios cover the documented cases; a randomized run follows.
//   Honours ALU_DIVZERO_EN the same way as the design.
module tb_alu_req_scheduler;
   localparam int WIDTH = 4;
   localparam int MASK  = (1 << WIDTH) - 1;
`ifdef ALU_DIVZERO_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]       req0_op, req1_op;
   logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
   logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [WIDTH-1:0] rsp_result;

   always #5 clk = ~clk;

   alu_req_scheduler #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Stimulus state
   logic             v0, v1, rr_in, rst_in;
   logic [1:0]       op0, op1;
   logic [WIDTH-1:0] a0, b0, a1, b1;
   bit               chk_on, hold0, hold1;
   int               last_g;
   int               grants[$];

   // Reference model: 0 idle, 1 computing, 2 result pending
   int m_phase, m_rem, m_rr, m_res, m_id, m_err;

   function automatic int ref_result(input logic [1:0] op, input int a, input int b);
      case (op)
         2'b00:   return (a + b) & MASK;
         2'b01:   return (a - b) & MASK;
         2'b10:   return (a * b) & MASK;
         default: return (b == 0) ? (DZ_EN ? 0 : MASK) : (a / b);
      endcase
   endfunction

   task automatic step();
      int g;
      logic [1:0] op;
      int a, b;
      rst = rst_in; rsp_ready = rr_in;
      req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
      #1;
      g = -1;
      if (m_phase == 0 && !rst_in) begin
         if (v0 && v1) g = m_rr;
         else if (v0)  g = 0;
         else if (v1)  g = 1;
      end
      if (chk_on) begin
         check_val("req0_ready", req0_ready, g == 0);
         check_val("req1_ready", req1_ready, g == 1);
         check_val("rsp_valid", rsp_valid, m_phase == 2);
         check_val("busy", busy, m_phase != 0);
         if (m_phase == 2) begin
            check_val("rsp_id", rsp_id, m_id);
            check_val("rsp_result", rsp_result, m_res);
            check_val("rsp_err", rsp_err, m_err);
         end
      end
      hold0 = !rst_in && v0 && (g != 0);
      hold1 = !rst_in && v1 && (g != 1);
      if (rst_in) begin
         m_phase = 0; m_rr = 0;
      end else begin
         case (m_phase)
            0: if (g >= 0) begin
               op = (g == 0) ? op0 : op1;
               a  = (g == 0) ? int'(a0) : int'(a1);
               b  = (g == 0) ? int'(b0) : int'(b1);
               m_id = g; m_rr = 1 - g; last_g = g;
               grants.push_back(g);
               m_res = ref_result(op, a, b);
               m_err = (DZ_EN && op == 2'b11 && b == 0) ? 1 : 0;
               if (op[1] == 1'b0 || m_err == 1) m_phase = 2;
               else begin m_phase = 1; m_rem = WIDTH; end
            end
            1: begin
               m_rem--;
               if (m_rem == 0) m_phase = 2;
            end
            default: if (rr_in) m_phase = 0;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic directed(input string tag, input int who, input logic [1:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int exp_res, input int exp_err, input int exp_lat,
                           input int hold);
      int n;
      last_g = -1;
      v0 = (who == 0); v1 = (who == 1);
      op0 = op; op1 = op; a0 = a; a1 = a; b0 = b; b1 = b; rr_in = 1'b1;
      step();
      check_val({tag, "_grant"}, last_g, who);
      v0 = 1'b0; v1 = 1'b0;
      a0 = '0; a1 = '0; b0 = '0; b1 = '0;   // later changes must not matter
      n = 1;
      while (rsp_valid !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check_val({tag, "_lat"}, n, exp_lat);
      check_val({tag, "_res"}, rsp_result, exp_res);
      check_val({tag, "_id"}, rsp_id, who);
      check_val({tag, "_err"}, rsp_err, exp_err);
      if (hold > 0) begin
         rr_in = 1'b0; v0 = 1'b1; v1 = 1'b1; op0 = 2'b00; op1 = 2'b00;
         for (int i = 0; i < hold; i++) begin
            step();
            check_val({tag, "_hold_res"}, rsp_result, exp_res);
            check_val({tag, "_hold_id"}, rsp_id, who);
         end
         v0 = 1'b0; v1 = 1'b0;
      end
      rr_in = 1'b1;
      step();
      check_val({tag, "_idle"}, busy, 0);
   endtask

   task automatic do_reset();
      v0 = 1'b0; v1 = 1'b0; rst_in = 1'b1;
      step();
      step();
      rst_in = 1'b0;
   endtask

   initial begin
      m_phase = 0; m_rem = 0; m_rr = 0; m_res = 0; m_id = 0; m_err = 0;
      v0 = 0; v1 = 0; op0 = 0; op1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0;
      rr_in = 1'b1; rst_in = 1'b1; chk_on = 1'b0; last_g = -1;
      hold0 = 0; hold1 = 0;
      @(negedge clk);
      step();                 // first reset edge; DUT state unknown before it
      chk_on = 1'b1;
      step();
      rst_in = 1'b0;
      check_val("rst_rsp_valid", rsp_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_rsp_id", rsp_id, 0);
      check_val("rst_rsp_result", rsp_result, 0);
      check_val("rst_rsp_err", rsp_err, 0);

      directed("add", 0, 2'b00, 4'd9, 4'd8, 1, 0, 1, 0);
      directed("sub", 1, 2'b01, 4'd3, 4'd5, 14, 0, 1, 0);
      directed("mul", 0, 2'b10, 4'd7, 4'd5, 3, 0, WIDTH + 1, 3);
      directed("mulmax", 1, 2'b10, 4'd15, 4'd15, 1, 0, WIDTH + 1, 0);
      directed("div", 1, 2'b11, 4'd13, 4'd4, 3, 0, WIDTH + 1, 0);
      directed("divsmall", 0, 2'b11, 4'd3, 4'd7, 0, 0, WIDTH + 1, 0);
      directed("div0", 0, 2'b11, 4'd5, 4'd0, DZ_EN ? 0 : 15, DZ_EN ? 1 : 0,
               DZ_EN ? 1 : WIDTH + 1, 0);

      // Round-robin under continuous contention
      do_reset();
      grants.delete();
      v0 = 1; v1 = 1; op0 = 2'b00; op1 = 2'b00;
      a0 = 4'd2; b0 = 4'd3; a1 = 4'd10; b1 = 4'd11; rr_in = 1'b1;
      for (int i = 0; i < 8; i++) step();
      v0 = 0; v1 = 0;
      check_val("rr_accepts", grants.size(), 4);
      for (int i = 0; i < 4; i++)
         check_val("rr_grant", (i < grants.size()) ? grants[i] : -1, i % 2);
      step();

      // Reset in the middle of a MUL
      v0 = 1; op0 = 2'b10; a0 = 4'd7; b0 = 4'd5;
      step();
      v0 = 0;
      step();
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      check_val("midrst_valid", rsp_valid, 0);
      check_val("midrst_busy", busy, 0);
      last_g = -1;
      v0 = 1; v1 = 1; op0 = 2'b00; op1 = 2'b00;
      step();
      check_val("midrst_rrptr", last_g, 0);
      v0 = 0; v1 = 0;
      for (int i = 0; i < 8; i++) step();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (!hold0) begin
            v0  = 1'($urandom_range(0, 1));
            op0 = 2'($urandom_range(0, 3));
            a0  = WIDTH'($urandom_range(0, MASK));
            b0  = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(0, MASK));
         end
         if (!hold1) begin
            v1  = 1'($urandom_range(0, 1));
            op1 = 2'($urandom_range(0, 3));
            a1  = WIDTH'($urandom_range(0, MASK));
            b1  = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(0, MASK));
         end
         rr_in  = ($urandom_range(0, 3) != 0);
         rst_in = ($urandom_range(0, 249) == 0);
         if (rst_in) begin v0 = 0; v1 = 0; end
         step();
      end
      rst_in = 1'b0; v0 = 0; v1 = 0; rr_in = 1'b1;
      for (int i = 0; i < WIDTH + 3; i++) step();
      check_val("drain_idle", busy, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
